alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and op encodings for the two-requester ALU share arbiter.
// One-hot op codes; anything that is not exactly one bit set is illegal.
package alu_share_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_SLT = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b10000;

  function automatic logic op_legal(input logic [4:0] op);
    return (op != 5'd0) && ((op & (op - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, combinational from req; pointer updates on upd.
// After reset requester 0 holds priority; a lone requester always wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last <= 1'b1;
    else if (upd) last <= upd_idx;
  end

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
    gnt = (en && (req != 2'b00)) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU: accept, EXEC, RESP.
// Legal op responds 2 cycles after accept, illegal op 1; response held until rsp_ready.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [4:0]       req_op0,
  input  logic [4:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, data_q;
  logic             g_q, zero_q, err_q;

  logic [1:0]       gnt;
  logic             gnt_idx;
  logic             acc, rsp_hs;
  logic [4:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Grant is suppressed while rst is high so nothing looks accepted during reset.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      ((state == IDLE) && !rst),
    .upd     (rsp_hs),
    .upd_idx (g_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign acc       = |(req_valid & req_ready);
  assign rsp_hs    = (state == RESP) && rsp_ready[g_q];
  assign sel_op    = gnt_idx ? req_op1 : req_op0;
  assign sel_a     = gnt_idx ? req_a1  : req_a0;
  assign sel_b     = gnt_idx ? req_b1  : req_b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = op_legal(sel_op) ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = 2'b00;
    alu_op    = 5'd0;
    alu_a     = '0;
    alu_b     = '0;
    busy      = (state != IDLE);
    case (state)
      EXEC: begin
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
      end
      RESP:    rsp_valid[g_q] = 1'b1;
      default: ;
    endcase
  end

  // An illegal op writes its error response at accept and never touches the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 5'd0;
      a_q    <= '0;
      b_q    <= '0;
      g_q    <= 1'b0;
      data_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (acc) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        g_q  <= gnt_idx;
        if (!op_legal(sel_op)) begin
          data_q <= '0;
          zero_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end
      if (state == EXEC) begin
        data_q <= alu_out;
        zero_q <= alu_zero;
        err_q  <= 1'b0;
      end
    end
  end

  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a scoreboard of expected responses
// and a behavioural model of the shared ALU.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  req_op0, req_op1, alu_op;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_data, alu_a, alu_b, alu_out;
  logic        rsp_zero, rsp_err, alu_zero, busy;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_SLT:  return (a < b) ? 32'd1 : 32'd0;
      OP_OR:   return a | b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_a == alu_b);

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        zero;
    logic        err;
    int          acc;
    int          lat;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   acc_order[$];
  int   acc_cyc[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc_n    = 0;
  int   base, n0;
  logic prev_rv  = 1'b0;
  logic auto_drop = 1'b1;
  logic alu_idle_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample settled outputs, score handshakes, advance to just after the edge.
  task automatic cyc();
    logic [1:0]  drop;
    exp_t        e, n;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        legal;
    #1;
    drop = 2'b00;
    chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
    chk("rsp_valid_onehot", ($countones(rsp_valid) <= 1), 1);
    if (alu_idle_chk) chk("alu_op_never_driven", alu_op, 0);
    if (sb.size() > 0) begin
      e = sb[0];
      if (e.lat == 2 && cyc_n == e.acc + 1) begin
        chk("exec_alu_op", alu_op, e.op);
        chk("exec_alu_a", alu_a, e.a);
        chk("exec_alu_b", alu_b, e.b);
      end
      if (rsp_valid != 2'b00 && !prev_rv) chk("rsp_latency", cyc_n - e.acc, e.lat);
      if (rsp_valid != 2'b00) begin
        chk("rsp_valid_bit", rsp_valid, (e.idx == 1) ? 2'b10 : 2'b01);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("rsp_err", rsp_err, e.err);
        if ((rsp_valid & rsp_ready) != 2'b00) void'(sb.pop_front());
      end
    end else if (rsp_valid != 2'b00) begin
      chk("unexpected_rsp", rsp_valid, 0);
    end
    for (int r = 0; r < 2; r++) begin
      if (req_valid[r] && req_ready[r]) begin
        op    = (r == 1) ? req_op1 : req_op0;
        a     = (r == 1) ? req_a1 : req_a0;
        b     = (r == 1) ? req_b1 : req_b0;
        legal = ($countones(op) == 1);
        n.idx  = r;
        n.data = legal ? alu_fn(op, a, b) : 32'd0;
        n.zero = legal ? (a == b) : 1'b0;
        n.err  = !legal;
        n.acc  = cyc_n;
        n.lat  = legal ? 2 : 1;
        n.op   = op;
        n.a    = a;
        n.b    = b;
        sb.push_back(n);
        acc_order.push_back(r);
        acc_cyc.push_back(cyc_n);
        if (auto_drop) drop[r] = 1'b1;
      end
    end
    prev_rv = |rsp_valid;
    @(posedge clk);
    cyc_n++;
    #1;
    req_valid = req_valid & ~drop;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != 2'b00) && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_drained"}, sb.size() + ((req_valid != 2'b00) ? 1 : 0), 0);
  endtask

  task automatic wait_acc(input string tag, input int budget);
    int start, n;
    start = acc_order.size();
    n = 0;
    while (acc_order.size() == start && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_accepted"}, acc_order.size() - start, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = 5'd0; req_op1 = 5'd0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    @(posedge clk); @(posedge clk); #1;
    req_valid = 2'b01; req_op0 = OP_ADD;
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_zero", rsp_zero, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_alu_op", alu_op, 0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Requester 0 ADD 5+7
    req_op0 = OP_ADD; req_a0 = 5; req_b0 = 7; rsp_ready = 2'b01; req_valid = 2'b01;
    wait_idle("add_req0", 20);
    chk("add_req0_grant", acc_order[$], 0);

    // Requester 1 SUB 9-9; rsp_ready on the other bit must be ignored
    req_op1 = OP_SUB; req_a1 = 9; req_b1 = 9; rsp_ready = 2'b01; req_valid = 2'b10;
    for (int i = 0; i < 5; i++) cyc();
    chk("sub_held_pending", sb.size(), 1);
    chk("sub_held_busy", busy, 1);
    rsp_ready = 2'b10;
    wait_idle("sub_req1", 20);

    // Both requesters valid continuously
    auto_drop = 1'b0;
    base = acc_order.size();
    req_op0 = OP_SLT; req_a0 = 3; req_b0 = 8;
    req_op1 = OP_AND; req_a1 = 32'hF0F0; req_b1 = 32'h0FF0;
    rsp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 12; i++) cyc();
    req_valid = 2'b00;
    wait_idle("rr", 20);
    chk("rr_accept_count", acc_order.size() - base, 4);
    if (acc_order.size() - base >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_order", acc_order[base + k], k % 2);
        if (k > 0) chk("rr_spacing", acc_cyc[base + k] - acc_cyc[base + k - 1], 3);
      end
    end
    auto_drop = 1'b1;

    // Illegal op on requester 0
    alu_idle_chk = 1'b1;
    req_op0 = 5'b00011; req_a0 = 11; req_b0 = 11; rsp_ready = 2'b01; req_valid = 2'b01;
    wait_idle("illegal", 20);
    alu_idle_chk = 1'b0;

    // OR with response backpressure; requester 0 waits behind it
    req_op1 = OP_OR; req_a1 = 32'hF0; req_b1 = 32'h0F; rsp_ready = 2'b00; req_valid = 2'b10;
    wait_acc("or_req1", 10);
    cyc();
    req_op0 = OP_AND; req_a0 = 32'hFF00; req_b0 = 32'h0FF0; req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_busy", busy, 1);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_rsp_valid", rsp_valid, 2'b10);
      cyc();
    end
    rsp_ready = 2'b11;
    wait_idle("stall", 20);

    // Reset during EXEC; last served is requester 0 so only reset gives it priority
    req_op0 = OP_ADD; req_a0 = 3; req_b0 = 4; rsp_ready = 2'b11; req_valid = 2'b01;
    wait_acc("rst_exec", 10);
    rst = 1'b1;
    #1;
    chk("rst_exec_rsp_valid", rsp_valid, 0);
    chk("rst_exec_busy", busy, 0);
    chk("rst_exec_alu_op", alu_op, 0);
    sb.delete();
    prev_rv = 1'b0;
    @(posedge clk); cyc_n++; #1;
    rst = 1'b0;
    n0 = acc_order.size();
    req_op0 = OP_SUB; req_a0 = 20; req_b0 = 6;
    req_op1 = OP_ADD; req_a1 = 1; req_b1 = 2;
    req_valid = 2'b11;
    cyc();
    chk("post_rst_accepted", acc_order.size() - n0, 1);
    if (acc_order.size() > n0) chk("post_rst_grant", acc_order[$], 0);
    wait_idle("post_rst", 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
